hazard_ctrl_unit: RTL and testbench

- Parametrised successor to the current combinational forwarding logic for the 5-stage SimpleRISC pipeline (IF, OF, EX, MA, RW).
- Generates forwarding selects for both EX operands and for store data, plus RW->MA load-to-store forwarding.
- Adds load-use stall detection and a counter-driven stall FSM for multi-cycle EX operations (mul/div).
- Sits beside the pipeline registers and drives their stall/bubble enables.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_fwd_sel.sv | 32 +++
 rtl/hazard_ctrl_unit.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the SimpleRISC hazard/forwarding unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_RW   = 2'b01,
        FWD_MA   = 2'b10
    } fwd_sel_t;

    localparam logic [4:0] OP_LD = 5'b01110;
    localparam logic [4:0] OP_ST = 5'b01111;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MC_BUSY = 1'b1
    } hc_state_t;

    // MA holds the younger result, so it wins over RW.
    function automatic fwd_sel_t fwd_prio(input logic hit_ma, input logic hit_rw);
        if (hit_ma)
            return FWD_MA;
        else if (hit_rw)
            return FWD_RW;
        else
            return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one EX source index: qualified MA/RW hits and priority encode.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned RW      = 4,
    parameter bit          R0_ZERO = 1'b0
) (
    input  logic [RW-1:0] src,
    input  logic          en,
    input  logic          ma_valid,
    input  logic          ma_is_wb,
    input  logic          ma_is_ld,
    input  logic [RW-1:0] ma_rd,
    input  logic          rw_valid,
    input  logic          rw_is_wb,
    input  logic [RW-1:0] rw_rd,
    output logic          hit_ma,
    output logic          hit_rw,
    output fwd_sel_t      sel
);

    logic src_ok;

    always_comb begin
        src_ok = en & (!R0_ZERO || (src != '0));
        // A load in MA has no data yet; that case is covered by the load-use stall.
        hit_ma = src_ok & ma_valid & ma_is_wb & ~ma_is_ld & (ma_rd == src);
        hit_rw = src_ok & rw_valid & rw_is_wb & (rw_rd == src);
        sel    = fwd_prio(hit_ma, hit_rw);
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Forwarding, load-use and multi-cycle EX stall control for the 5-stage SimpleRISC pipeline.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned NREG    = 16,
    parameter int unsigned RW      = $clog2(NREG),
    parameter int unsigned MC_LAT  = 4,
    parameter bit          R0_ZERO = 1'b0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             of_valid,
    input  logic [RW-1:0]    of_rs1,
    input  logic [RW-1:0]    of_rs2,
    input  logic             of_use_rs1,
    input  logic             of_use_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_wb,
    input  logic             ex_is_ld,
    input  logic             ex_is_st,
    input  logic [RW-1:0]    ex_rd,
    input  logic [RW-1:0]    ex_rs1,
    input  logic [RW-1:0]    ex_rs2,
    input  logic             ex_mc_start,
    input  logic             ma_valid,
    input  logic             ma_is_wb,
    input  logic             ma_is_ld,
    input  logic             ma_is_st,
    input  logic [RW-1:0]    ma_rd,
    input  logic             rw_valid,
    input  logic             rw_is_wb,
    input  logic             rw_is_ld,
    input  logic [RW-1:0]    rw_rd,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic [1:0]       fwd_st_e,
    output logic             fwd_rw_ma,
    output logic             stall_if,
    output logic             stall_of,
    output logic             stall_ex,
    output logic             bubble_ex,
    output logic             bubble_ma,
    output logic             mc_busy,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] mc_stall_cnt
);

    localparam bit         MC_EN   = (MC_LAT > 1);
    localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 1);

    fwd_sel_t  sel_a, sel_b, sel_st;
    logic      hit_ma_a, hit_rw_a, hit_ma_b, hit_rw_b, hit_ma_st, hit_rw_st;
    hc_state_t state;
    logic [3:0] cnt;
    logic      mc_start_acc, mc_stall, lu_raw, lu, rw_ma_hit;
    logic      unused_ok;

    hazard_fwd_sel #(.RW(RW), .R0_ZERO(R0_ZERO)) u_fwd_a (
        .src(ex_rs1), .en(1'b1),
        .ma_valid(ma_valid), .ma_is_wb(ma_is_wb), .ma_is_ld(ma_is_ld), .ma_rd(ma_rd),
        .rw_valid(rw_valid), .rw_is_wb(rw_is_wb), .rw_rd(rw_rd),
        .hit_ma(hit_ma_a), .hit_rw(hit_rw_a), .sel(sel_a)
    );

    hazard_fwd_sel #(.RW(RW), .R0_ZERO(R0_ZERO)) u_fwd_b (
        .src(ex_rs2), .en(1'b1),
        .ma_valid(ma_valid), .ma_is_wb(ma_is_wb), .ma_is_ld(ma_is_ld), .ma_rd(ma_rd),
        .rw_valid(rw_valid), .rw_is_wb(rw_is_wb), .rw_rd(rw_rd),
        .hit_ma(hit_ma_b), .hit_rw(hit_rw_b), .sel(sel_b)
    );

    hazard_fwd_sel #(.RW(RW), .R0_ZERO(R0_ZERO)) u_fwd_st (
        .src(ex_rd), .en(ex_is_st),
        .ma_valid(ma_valid), .ma_is_wb(ma_is_wb), .ma_is_ld(ma_is_ld), .ma_rd(ma_rd),
        .rw_valid(rw_valid), .rw_is_wb(rw_is_wb), .rw_rd(rw_rd),
        .hit_ma(hit_ma_st), .hit_rw(hit_rw_st), .sel(sel_st)
    );

    always_comb begin
        rw_ma_hit = rw_valid & rw_is_ld & ma_valid & ma_is_st & (rw_rd == ma_rd)
                    & (!R0_ZERO || (rw_rd != '0));

        mc_start_acc = MC_EN & (state == ST_IDLE) & ex_valid & ex_mc_start;
        mc_stall     = mc_start_acc | ((state == ST_MC_BUSY) & (cnt != 4'd1));

        lu_raw = ex_valid & ex_is_ld & of_valid & (!R0_ZERO || (ex_rd != '0))
                 & ((of_use_rs1 & (of_rs1 == ex_rd)) | (of_use_rs2 & (of_rs2 == ex_rd)));
        // A held multi-cycle op already freezes OF, so load-use must not also bubble EX.
        lu = lu_raw & ~mc_stall;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mc_start_acc) begin
                        state <= ST_MC_BUSY;
                        cnt   <= MC_LOAD;
                    end
                end
                ST_MC_BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        fwd_a_e   = rst ? '0 : sel_a;
        fwd_b_e   = rst ? '0 : sel_b;
        fwd_st_e  = rst ? '0 : sel_st;
        fwd_rw_ma = ~rst & rw_ma_hit;
        stall_if  = ~rst & (mc_stall | lu);
        stall_of  = ~rst & (mc_stall | lu);
        stall_ex  = ~rst & mc_stall;
        bubble_ex = ~rst & lu;
        bubble_ma = ~rst & mc_stall;
        mc_busy   = ~rst & (state == ST_MC_BUSY);
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt_q, mc_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_cnt_q <= '0;
            mc_cnt_q <= '0;
        end else begin
            if (lu && (lu_cnt_q != '1))
                lu_cnt_q <= lu_cnt_q + CNT_W'(1);
            if (mc_stall && (mc_cnt_q != '1))
                mc_cnt_q <= mc_cnt_q + CNT_W'(1);
        end
    end

    assign lu_stall_cnt = lu_cnt_q;
    assign mc_stall_cnt = mc_cnt_q;
`else
    assign lu_stall_cnt = '0;
    assign mc_stall_cnt = '0;
`endif

    assign unused_ok = &{1'b0, ex_is_wb, hit_ma_a, hit_rw_a, hit_ma_b, hit_rw_b,
                         hit_ma_st, hit_rw_st};

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: driver queues expected outputs, negedge monitor compares.
module tb_hazard_ctrl_unit;

    localparam int unsigned NREG = 16;
    localparam int unsigned RWD  = 4;
    localparam int unsigned CW   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            of_valid, of_use_rs1, of_use_rs2;
    logic [RWD-1:0]  of_rs1, of_rs2;
    logic            ex_valid, ex_is_wb, ex_is_ld, ex_is_st, ex_mc_start;
    logic [RWD-1:0]  ex_rd, ex_rs1, ex_rs2;
    logic            ma_valid, ma_is_wb, ma_is_ld, ma_is_st;
    logic [RWD-1:0]  ma_rd;
    logic            rw_valid, rw_is_wb, rw_is_ld;
    logic [RWD-1:0]  rw_rd;

    logic [1:0]      fwd_a_e, fwd_b_e, fwd_st_e;
    logic            fwd_rw_ma, stall_if, stall_of, stall_ex, bubble_ex, bubble_ma, mc_busy;
    logic [CW-1:0]   lu_stall_cnt, mc_stall_cnt;

    logic [1:0]      r0_fwd_a_e, r0_fwd_b_e, r0_fwd_st_e;
    logic            r0_fwd_rw_ma, r0_stall_if, r0_stall_of, r0_stall_ex;
    logic            r0_bubble_ex, r0_bubble_ma, r0_mc_busy;
    logic [CW-1:0]   r0_lu_stall_cnt, r0_mc_stall_cnt;

    hazard_ctrl_unit #(.NREG(NREG), .MC_LAT(4), .R0_ZERO(1'b0), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .of_valid(of_valid), .of_rs1(of_rs1), .of_rs2(of_rs2),
        .of_use_rs1(of_use_rs1), .of_use_rs2(of_use_rs2),
        .ex_valid(ex_valid), .ex_is_wb(ex_is_wb), .ex_is_ld(ex_is_ld), .ex_is_st(ex_is_st),
        .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_mc_start(ex_mc_start),
        .ma_valid(ma_valid), .ma_is_wb(ma_is_wb), .ma_is_ld(ma_is_ld), .ma_is_st(ma_is_st),
        .ma_rd(ma_rd),
        .rw_valid(rw_valid), .rw_is_wb(rw_is_wb), .rw_is_ld(rw_is_ld), .rw_rd(rw_rd),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_st_e(fwd_st_e), .fwd_rw_ma(fwd_rw_ma),
        .stall_if(stall_if), .stall_of(stall_of), .stall_ex(stall_ex),
        .bubble_ex(bubble_ex), .bubble_ma(bubble_ma), .mc_busy(mc_busy),
        .lu_stall_cnt(lu_stall_cnt), .mc_stall_cnt(mc_stall_cnt)
    );

    hazard_ctrl_unit #(.NREG(NREG), .MC_LAT(4), .R0_ZERO(1'b1), .CNT_W(CW)) dut_r0 (
        .clk(clk), .rst(rst),
        .of_valid(of_valid), .of_rs1(of_rs1), .of_rs2(of_rs2),
        .of_use_rs1(of_use_rs1), .of_use_rs2(of_use_rs2),
        .ex_valid(ex_valid), .ex_is_wb(ex_is_wb), .ex_is_ld(ex_is_ld), .ex_is_st(ex_is_st),
        .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_mc_start(ex_mc_start),
        .ma_valid(ma_valid), .ma_is_wb(ma_is_wb), .ma_is_ld(ma_is_ld), .ma_is_st(ma_is_st),
        .ma_rd(ma_rd),
        .rw_valid(rw_valid), .rw_is_wb(rw_is_wb), .rw_is_ld(rw_is_ld), .rw_rd(rw_rd),
        .fwd_a_e(r0_fwd_a_e), .fwd_b_e(r0_fwd_b_e), .fwd_st_e(r0_fwd_st_e),
        .fwd_rw_ma(r0_fwd_rw_ma),
        .stall_if(r0_stall_if), .stall_of(r0_stall_of), .stall_ex(r0_stall_ex),
        .bubble_ex(r0_bubble_ex), .bubble_ma(r0_bubble_ma), .mc_busy(r0_mc_busy),
        .lu_stall_cnt(r0_lu_stall_cnt), .mc_stall_cnt(r0_mc_stall_cnt)
    );

    typedef struct packed {
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic [1:0]    fst;
        logic [1:0]    fb0;
        logic          frm;
        logic          sif;
        logic          sof;
        logic          sex;
        logic          bex;
        logic          bma;
        logic          busy;
        logic [CW-1:0] luc;
        logic [CW-1:0] mcc;
    } exp_t;

    exp_t          exp_q[$];
    string         name_q[$];
    int unsigned   n_chk = 0;
    int unsigned   n_fail = 0;
    logic [CW-1:0] m_lu = '0;
    logic [CW-1:0] m_mc = '0;

    task automatic clr();
        of_valid = 0; of_use_rs1 = 0; of_use_rs2 = 0; of_rs1 = '0; of_rs2 = '0;
        ex_valid = 0; ex_is_wb = 0; ex_is_ld = 0; ex_is_st = 0; ex_mc_start = 0;
        ex_rd = '0; ex_rs1 = '0; ex_rs2 = '0;
        ma_valid = 0; ma_is_wb = 0; ma_is_ld = 0; ma_is_st = 0; ma_rd = '0;
        rw_valid = 0; rw_is_wb = 0; rw_is_ld = 0; rw_rd = '0;
    endtask

    // ctl = {fwd_rw_ma, stall_if, stall_of, stall_ex, bubble_ex, bubble_ma, mc_busy}
    task automatic chk(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [1:0] fst, input logic [1:0] fb0, input logic [6:0] ctl);
        exp_t e;
        if (rst) begin
            m_lu = '0;
            m_mc = '0;
        end
        e.fa = fa; e.fb = fb; e.fst = fst; e.fb0 = fb0;
        {e.frm, e.sif, e.sof, e.sex, e.bex, e.bma, e.busy} = ctl;
`ifdef HAZARD_PERF_CNT_EN
        e.luc = m_lu;
        e.mcc = m_mc;
`else
        e.luc = '0;
        e.mcc = '0;
`endif
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (!rst) begin
            if (ctl[2] && (m_lu != '1)) m_lu = m_lu + CW'(1);
            if (ctl[3] && (m_mc != '1)) m_mc = m_mc + CW'(1);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t  e;
        exp_t  a;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a.fa = fwd_a_e; a.fb = fwd_b_e; a.fst = fwd_st_e; a.fb0 = r0_fwd_b_e;
            a.frm = fwd_rw_ma; a.sif = stall_if; a.sof = stall_of; a.sex = stall_ex;
            a.bex = bubble_ex; a.bma = bubble_ma; a.busy = mc_busy;
            a.luc = lu_stall_cnt; a.mcc = mc_stall_cnt;
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", nm, a, e);
            end
        end
    end

    initial begin
        clr();
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Outputs must stay low in reset even with hazards presented.
        ma_valid = 1; ma_is_wb = 1; ma_rd = 4'd3; ex_rs1 = 4'd3;
        ex_valid = 1; ex_mc_start = 1;
        chk("reset_gate", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0000000);
        rst = 1'b0;
        clr();
        chk("idle_after_reset", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0000000);

        ma_valid = 1; ma_is_wb = 1; ma_rd = 4'd3;
        rw_valid = 1; rw_is_wb = 1; rw_rd = 4'd3; ex_rs1 = 4'd3;
        chk("fwd_a_ma_prio", 2'b10, 2'b00, 2'b00, 2'b00, 7'b0000000);
        ma_valid = 0;
        chk("fwd_a_rw", 2'b01, 2'b00, 2'b00, 2'b00, 7'b0000000);
        ma_valid = 1; ex_rs1 = 4'd1; ex_rs2 = 4'd2; ex_rd = 4'd3; ex_is_st = 1;
        chk("fwd_st_ma", 2'b00, 2'b00, 2'b10, 2'b00, 7'b0000000);
        ex_is_st = 0;
        chk("fwd_st_not_store", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0000000);
        ma_valid = 0; ex_rs2 = 4'd3;
        chk("fwd_b_rw", 2'b00, 2'b01, 2'b00, 2'b01, 7'b0000000);

        clr();
        ex_valid = 1; ex_is_ld = 1; ex_rd = 4'd5;
        of_valid = 1; of_rs2 = 4'd5; of_use_rs2 = 1;
        chk("lu_rs2", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0110100);
        clr();
        chk("lu_release", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0000000);
        ex_valid = 1; ex_is_ld = 1; ex_rd = 4'd5;
        of_valid = 1; of_rs2 = 4'd5; of_use_rs2 = 0;
        chk("lu_store_data", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0000000);

        clr();
        rw_valid = 1; rw_is_wb = 1; rw_is_ld = 1; rw_rd = 4'd7;
        ma_valid = 1; ma_is_st = 1; ma_rd = 4'd7; ex_rs1 = 4'd7;
        chk("rw_ld_to_st", 2'b01, 2'b00, 2'b00, 2'b00, 7'b1000000);
        clr();
        ma_valid = 1; ma_is_wb = 1; ma_is_ld = 1; ma_rd = 4'd7; ex_rs1 = 4'd7;
        chk("ma_ld_no_fwd", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0000000);

        clr();
        ma_valid = 1; ma_is_wb = 1; ma_rd = 4'd0;
        chk("r0_fwd", 2'b10, 2'b10, 2'b00, 2'b00, 7'b0000000);

        // Multi-cycle op with a concurrent load-use that must be masked.
        clr();
        ex_valid = 1; ex_mc_start = 1; ex_is_ld = 1; ex_rd = 4'd5;
        of_valid = 1; of_rs1 = 4'd5; of_use_rs1 = 1;
        chk("mc_start", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0111010);
        chk("mc_busy1", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0111011);
        chk("mc_busy2", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0111011);
        ex_is_ld = 0; of_valid = 0;
        chk("mc_last", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0000001);
        ex_is_ld = 1; of_valid = 1;
        chk("mc_b2b_start", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0111010);
        ex_mc_start = 0; ex_is_ld = 0; of_valid = 0;
        chk("mc_b2b_busy1", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0111011);
        chk("mc_b2b_busy2", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0111011);
        chk("mc_b2b_last", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0000001);
        chk("mc_idle", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0000000);

        ex_mc_start = 1;
        chk("mc_pre_reset", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0111010);
        rst = 1'b1;
        chk("mc_reset_abort", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0000000);
        rst = 1'b0;
        ex_mc_start = 0;
        chk("post_reset_idle", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0000000);

        clr();
        ex_valid = 1; ex_is_ld = 1; ex_rd = 4'd5;
        of_valid = 1; of_rs1 = 4'd5; of_use_rs1 = 1;
        for (int i = 0; i < 5; i++)
            chk("lu_sat", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0110100);
        clr();
        chk("lu_sat_final", 2'b00, 2'b00, 2'b00, 2'b00, 7'b0000000);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
